// File: rtl/pipeline_bp_reg.sv
// Backpressure-registered pipeline stage: forward path is combinational when empty,
// d_bp comes from the skid flop so q_bp never reaches upstream in the same cycle.
module pipeline_bp_reg #(
    parameter int Width = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [Width-1:0] d,
    input  logic             d_valid,
    output logic             d_bp,
    output logic [Width-1:0] q,
    output logic             q_valid,
    input  logic             q_bp
);

    logic             skid_valid;
    logic [Width-1:0] skid_data;
    logic             capture;

    // Handshake: a token moves on a rising edge when valid=1 and bp=0 in that cycle;
    // an unaccepted upstream token stays presented with d/d_valid stable.
    assign d_bp    = ~resetn | skid_valid;
    assign q_valid = resetn & (skid_valid | d_valid);
    assign q       = skid_valid ? skid_data : d;

    // Capture only into an empty skid, so a held token is never overwritten.
    assign capture = resetn & ~skid_valid & d_valid & q_bp;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            if (!q_bp) begin
                skid_valid <= 1'b0;
            end
        end else if (capture) begin
            skid_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            skid_data <= d;
        end
    end

endmodule

// File: tb/tb_pipeline_bp_reg.sv
// Self-checking bench for pipeline_bp_reg: directed vector table, streaming,
// random scoreboard run with d_bp independence check.
module tb_pipeline_bp_reg;

    localparam int W = 8;

    logic         clk;
    logic         resetn;
    logic [W-1:0] d;
    logic         d_valid;
    logic         d_bp;
    logic [W-1:0] q;
    logic         q_valid;
    logic         q_bp;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];

    typedef struct {
        logic         rst_n;
        logic         dv;
        logic [W-1:0] dd;
        logic         qbp;
        logic         e_dbp;
        logic         e_qv;
        logic [W-1:0] e_q;
    } vec_t;

    vec_t vecs[23];
    int   n_vecs = 0;

    pipeline_bp_reg #(.Width(W)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .d       (d),
        .d_valid (d_valid),
        .d_bp    (d_bp),
        .q       (q),
        .q_valid (q_valid),
        .q_bp    (q_bp)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input logic rst_n, input logic dv, input logic [W-1:0] dd,
                           input logic qbp, input logic e_dbp, input logic e_qv,
                           input logic [W-1:0] e_q);
        vecs[n_vecs] = '{rst_n, dv, dd, qbp, e_dbp, e_qv, e_q};
        n_vecs++;
    endtask

    // driver: called just after a rising edge; checks at the falling edge
    task automatic apply_vec(input int i);
        resetn  = vecs[i].rst_n;
        d_valid = vecs[i].dv;
        d       = vecs[i].dd;
        q_bp    = vecs[i].qbp;
        @(negedge clk);
        chk($sformatf("vec%0d_d_bp", i), {31'b0, d_bp}, {31'b0, vecs[i].e_dbp});
        chk($sformatf("vec%0d_q_valid", i), {31'b0, q_valid}, {31'b0, vecs[i].e_qv});
        if (vecs[i].e_qv) chk($sformatf("vec%0d_q", i), {24'b0, q}, {24'b0, vecs[i].e_q});
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic bp_a;
        logic acc;
        logic del;
        logic pending;
        int   accepted;
        int   cycles;
        int   delivered;

        resetn  = 1'b0;
        d       = '0;
        d_valid = 1'b0;
        q_bp    = 1'b0;

        //      rst dv d      qbp  dbp qv q
        // reset held 3 cycles with a token presented, then release
        add_vec(0, 1, 8'h5A, 0,   1,  0, 8'h00);
        add_vec(0, 1, 8'h5A, 0,   1,  0, 8'h00);
        add_vec(0, 1, 8'h5A, 0,   1,  0, 8'h00);
        add_vec(1, 1, 8'h5A, 0,   0,  1, 8'h5A);
        // stall capture: 0x02 absorbed into skid, 0x03 held upstream
        add_vec(1, 1, 8'h01, 0,   0,  1, 8'h01);
        add_vec(1, 1, 8'h02, 1,   0,  1, 8'h02);
        add_vec(1, 1, 8'h03, 1,   1,  1, 8'h02);
        add_vec(1, 1, 8'h03, 1,   1,  1, 8'h02);
        add_vec(1, 1, 8'h03, 1,   1,  1, 8'h02);
        add_vec(1, 1, 8'h03, 0,   1,  1, 8'h02);
        add_vec(1, 1, 8'h03, 0,   0,  1, 8'h03);
        add_vec(1, 0, 8'h00, 0,   0,  0, 8'h00);
        // reset with full skid: 0xAA discarded, 0xBB held through reset
        add_vec(1, 1, 8'hAA, 1,   0,  1, 8'hAA);
        add_vec(0, 1, 8'hBB, 0,   1,  0, 8'h00);
        add_vec(1, 1, 8'hBB, 0,   0,  1, 8'hBB);
        add_vec(1, 0, 8'h00, 0,   0,  0, 8'h00);
        // alternating q_bp: one token per two cycles, d_bp one cycle behind
        add_vec(1, 1, 8'hC1, 1,   0,  1, 8'hC1);
        add_vec(1, 1, 8'hC2, 0,   1,  1, 8'hC1);
        add_vec(1, 1, 8'hC2, 1,   0,  1, 8'hC2);
        add_vec(1, 1, 8'hC3, 0,   1,  1, 8'hC2);
        add_vec(1, 1, 8'hC3, 1,   0,  1, 8'hC3);
        add_vec(1, 1, 8'hC4, 0,   1,  1, 8'hC3);
        add_vec(1, 0, 8'h00, 0,   0,  0, 8'h00);

        @(posedge clk);
        #1;
        for (int i = 0; i < n_vecs; i++) apply_vec(i);

        // streaming: zero latency, d_bp low, 16 tokens in 16 cycles
        delivered = 0;
        for (int i = 1; i <= 16; i++) begin
            resetn  = 1'b1;
            d_valid = 1'b1;
            d       = W'(i);
            q_bp    = 1'b0;
            @(negedge clk);
            chk("stream_q", {24'b0, q}, i);
            chk("stream_d_bp", {31'b0, d_bp}, 0);
            if (q_valid && !q_bp) delivered++;
            @(posedge clk);
            #1;
        end
        chk("stream_count", delivered, 16);
        d_valid = 1'b0;

        // random stress with scoreboard
        pending  = 1'b0;
        accepted = 0;
        cycles   = 0;
        while (accepted < 1000 && cycles < 20000) begin
            cycles++;
            if (!pending) begin
                if ($urandom_range(0, 1) == 1) begin
                    d       = W'($urandom_range(0, 255));
                    d_valid = 1'b1;
                    pending = 1'b1;
                end else begin
                    d_valid = 1'b0;
                end
            end
            q_bp = 1'($urandom_range(0, 1));
            @(negedge clk);
            bp_a = d_bp;
            q_bp = ~q_bp;
            #1;
            chk("d_bp_indep_of_q_bp", {31'b0, d_bp}, {31'b0, bp_a});
            q_bp = ~q_bp;
            #1;
            acc = d_valid && !d_bp;
            del = q_valid && !q_bp;
            if (acc) begin
                exp_q.push_back(d);
                pending = 1'b0;
                accepted++;
            end
            if (del) begin
                if (exp_q.size() == 0) chk("rand_spurious_token", {24'b0, q}, 32'hFFFF_FFFF);
                else chk("rand_q", {24'b0, q}, {24'b0, exp_q.pop_front()});
            end
            chk("rand_occupancy_le1", {31'b0, exp_q.size() <= 1}, 1);
            @(posedge clk);
            #1;
        end
        chk("rand_accepted", accepted, 1000);

        // drain
        d_valid = 1'b0;
        q_bp    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (q_valid) begin
                if (exp_q.size() == 0) chk("drain_spurious_token", {24'b0, q}, 32'hFFFF_FFFF);
                else chk("drain_q", {24'b0, q}, {24'b0, exp_q.pop_front()});
            end
            @(posedge clk);
            #1;
        end
        chk("drain_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
